// File: rtl/dmem_responder.sv
// Word-addressed scratchpad responder for the data memory command bus, with programmable wait states.
// Optional out-of-range detection is compiled in with `define DMEM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | no command in flight, ready to accept
// WAIT  | command latched, counting wait states, Mem_Stall high
// DONE  | command committed, Mem_Ready high, next command may be accepted
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] Mem_Address,
  input  logic        Mem_ReadEnable,
  input  logic [3:0]  Mem_WriteEnable,
  input  logic [31:0] Mem_WriteData,
  output logic [31:0] Mem_ReadData,
  output logic        Mem_Ready,
  output logic        Mem_Stall,
  output logic        Mem_Error
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int          WAIT_LOAD_I = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
  localparam logic [3:0]  WAIT_LOAD   = WAIT_LOAD_I[3:0];

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [29:0] req_addr;
  logic        req_rd;
  logic [3:0]  req_we;
  logic [31:0] req_wd;
  logic        err_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  cmd_present;
  logic                  accept;
  logic                  commit;
  logic [29:0]           c_addr;
  logic                  c_rd;
  logic [3:0]            c_we;
  logic [31:0]           c_wd;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic                  in_range;
  logic                  wr_en;

  assign cmd_present = Mem_ReadEnable | (|Mem_WriteEnable);
  assign accept      = (state != WAIT) && cmd_present;

  // With no wait states the commit edge is the acceptance edge, so the live bus is committed directly.
  assign commit = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (wait_cnt == 4'd0));
  assign c_addr = (WAIT_CYCLES == 0) ? Mem_Address     : req_addr;
  assign c_rd   = (WAIT_CYCLES == 0) ? Mem_ReadEnable  : req_rd;
  assign c_we   = (WAIT_CYCLES == 0) ? Mem_WriteEnable : req_we;
  assign c_wd   = (WAIT_CYCLES == 0) ? Mem_WriteData   : req_wd;
  assign c_idx  = c_addr[ADDR_WIDTH-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (c_addr[29:ADDR_WIDTH] == '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^c_addr[29:ADDR_WIDTH];
  assign in_range       = 1'b1;
`endif

  // A reset on the commit edge cancels the pending write.
  assign wr_en = commit && in_range && !reset;

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && c_we[b]) mem[c_idx][8*b +: 8] <= c_wd[8*b +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      Mem_ReadData <= 32'd0;
      err_q        <= 1'b0;
      req_addr     <= 30'd0;
      req_rd       <= 1'b0;
      req_we       <= 4'd0;
      req_wd       <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cmd_present) begin
            req_addr <= Mem_Address;
            req_rd   <= Mem_ReadEnable;
            req_we   <= Mem_WriteEnable;
            req_wd   <= Mem_WriteData;
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= DONE;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase

      // Old word is sampled before the same-edge write lands (read-before-write).
      if (commit && c_rd) Mem_ReadData <= in_range ? mem[c_idx] : 32'd0;
      err_q <= commit && !in_range;
    end
  end

  assign Mem_Ready = (state == DONE);
  assign Mem_Stall = (state == WAIT);

`ifdef DMEM_RANGE_CHECK_EN
  assign Mem_Error = err_q;
`else
  assign Mem_Error = 1'b0;
`endif

endmodule
